// File: rtl/fpu_addsub_seq.sv
// Sequential floating-point adder/subtractor: one datapath step per FSM state,
// round-to-nearest-even, denormal inputs flushed to signed zero.
module fpu_addsub_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic [EXP_W+MAN_W:0] R,
    output logic                 done,
    output logic                 busy,
    output logic [3:0]           flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned DW = MAN_W + 5;
    localparam int unsigned XW = EXP_W + $clog2(DW) + 2;
    localparam logic [EXP_W-1:0]    EMAX   = '1;
    localparam logic signed [XW-1:0] EMAX_X = {{(XW-EXP_W){1'b0}}, EMAX};
    localparam logic [W-1:0]        QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;
    state_e state;

    logic [W-1:0]         a_q, b_q, spec_r_q, res_q;
    logic                 op_q, spec_q, sign_q, sub_q, zero_q;
    logic [3:0]           spec_f_q, res_f_q;
    logic [EXP_W-1:0]     exp_q;
    logic [DW-1:0]        big_q, small_q, sum_q;
    logic [DW-2:0]        m_q;
    logic signed [XW-1:0] e_q;

    // Align: classify, order by magnitude, shift the smaller operand with sticky
    logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap, spec;
    logic [EXP_W-1:0] ea, eb, big_e, small_e, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb, small_m;
    logic [DW-1:0]    big_x, small_x, lost, aligned;
    logic [W-1:0]     spec_r;
    logic [3:0]       spec_f;

    always_comb begin
        sa      = a_q[W-1];
        sb      = b_q[W-1] ^ op_q;
        ea      = a_q[W-2:MAN_W];
        eb      = b_q[W-2:MAN_W];
        fa      = a_q[MAN_W-1:0];
        fb      = b_q[MAN_W-1:0];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_nan   = (ea == EMAX) && (fa != '0);
        b_nan   = (eb == EMAX) && (fb != '0);
        a_inf   = (ea == EMAX) && (fa == '0);
        b_inf   = (eb == EMAX) && (fb == '0);
        ma      = a_zero ? '0 : {1'b1, fa};
        mb      = b_zero ? '0 : {1'b1, fb};
        swap    = {eb, mb[MAN_W-1:0]} > {ea, ma[MAN_W-1:0]};
        big_e   = swap ? eb : ea;
        small_e = swap ? ea : eb;
        small_m = swap ? ma : mb;
        big_x   = {1'b0, swap ? mb : ma, 3'b000};
        small_x = {1'b0, small_m, 3'b000};
        diff    = big_e - small_e;
        lost    = small_x & ~({DW{1'b1}} << diff);
        if (32'(diff) >= MAN_W + 3) begin
            aligned = {{(DW-1){1'b0}}, |small_m};
        end else begin
            aligned = (small_x >> diff) | {{(DW-1){1'b0}}, |lost};
        end

        spec   = 1'b1;
        spec_f = 4'b0000;
        spec_r = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_r = QNAN;
            spec_f = 4'b1000;
        end else if (a_inf) begin
            spec_r = {sa, EMAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_r = {sb, EMAX, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_r = {sa & sb, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // Normalise: carry-out shifts right keeping sticky, otherwise shift out leading zeros
    logic [XW-1:0]        lzc;
    logic [DW-2:0]        norm_m;
    logic signed [XW-1:0] e_ext, e_norm;

    always_comb begin
        lzc = XW'(DW - 1);
        for (int unsigned i = 0; i < DW - 1; i++) begin
            if (sum_q[i]) lzc = XW'(DW - 2 - i);
        end
        e_ext = $signed({{(XW-EXP_W){1'b0}}, exp_q});
        if (sum_q[DW-1]) begin
            norm_m = {sum_q[DW-1:2], sum_q[1] | sum_q[0]};
            e_norm = e_ext + XW'(1);
        end else begin
            norm_m = sum_q[DW-2:0] << lzc;
            e_norm = e_ext - $signed(lzc);
        end
    end

    logic                 inexact, up;
    logic [MAN_W+1:0]     rnd;
    logic signed [XW-1:0] e_rnd;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         res;
    logic [3:0]           res_f;

    always_comb begin
        inexact = |m_q[2:0];
        up      = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        rnd     = {1'b0, m_q[DW-2:3]} + {{(MAN_W+1){1'b0}}, up};
        e_rnd   = e_q + $signed({{(XW-1){1'b0}}, rnd[MAN_W+1]});
        frac    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        if (spec_q) begin
            res   = spec_r_q;
            res_f = spec_f_q;
        end else if (zero_q) begin
            res   = '0;
            res_f = 4'b0000;
        end else if (e_q[XW-1] || (e_q == '0)) begin
            res   = {sign_q, {(W-1){1'b0}}};
            res_f = 4'b0011;
        end else if (e_rnd >= EMAX_X) begin
            res   = {sign_q, EMAX, {MAN_W{1'b0}}};
            res_f = 4'b0101;
        end else begin
            res   = {sign_q, e_rnd[EXP_W-1:0], frac};
            res_f = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            R        <= '0;
            flags    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            spec_q   <= 1'b0;
            spec_r_q <= '0;
            spec_f_q <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            big_q    <= '0;
            small_q  <= '0;
            sum_q    <= '0;
            m_q      <= '0;
            e_q      <= '0;
            zero_q   <= 1'b0;
            res_q    <= '0;
            res_f_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= StAlign;
                    end
                end
                StAlign: begin
                    spec_q   <= spec;
                    spec_r_q <= spec_r;
                    spec_f_q <= spec_f;
                    sign_q   <= swap ? sb : sa;
                    sub_q    <= sa ^ sb;
                    exp_q    <= big_e;
                    big_q    <= big_x;
                    small_q  <= aligned;
                    state    <= StAdd;
                end
                StAdd: begin
                    sum_q <= sub_q ? big_q - small_q : big_q + small_q;
                    state <= StNorm;
                end
                StNorm: begin
                    m_q    <= norm_m;
                    e_q    <= e_norm;
                    zero_q <= (sum_q == '0);
                    state  <= StRound;
                end
                StRound: begin
                    res_q   <= res;
                    res_f_q <= res_f;
                    state   <= StDone;
                end
                StDone: begin
                    R     <= res_q;
                    flags <= res_f_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
